// File: rtl/joy_serial_reader.sv
// joy_serial_reader: drives a shift-register joystick adapter, clocks in PLAYERS*BITS active-low
// buttons per frame, debounces whole frames and reports active-high button words plus link status.
module joy_serial_reader #(
    parameter int PLAYERS   = 2,
    parameter int BITS      = 12,
    parameter int SHIFT_DIV = 24,
    parameter int GAP_TICKS = 64,
    parameter int DEBOUNCE  = 2
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    joy_data,
    output logic                    joy_clk,
    output logic                    joy_load,
    output logic [PLAYERS*BITS-1:0] joystick,
    output logic                    frame,
    output logic                    present
);
    localparam int N  = PLAYERS * BITS;
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam int CW = $clog2(SHIFT_DIV);
    localparam int GW = (GAP_TICKS > 1) ? $clog2(GAP_TICKS) : 1;
    localparam logic [IW-1:0] ILAST = IW'(N - 1);
    localparam logic [CW-1:0] CLAST = CW'(SHIFT_DIV - 1);
    localparam logic [GW-1:0] GLAST = GW'(GAP_TICKS - 1);
    localparam logic [2:0]    DB    = 3'(DEBOUNCE);

    typedef enum logic [2:0] {LOAD, SETTLE, LOW, HIGH, LATCH, GAP} state_t;

    state_t        state;
    logic [1:0]    rst_q, sd_q;
    logic          rst_n, sd, tick;
    logic [CW-1:0] cnt;
    logic [IW-1:0] idx;
    logic [GW-1:0] gcnt;
    logic [N-1:0]  shadow, prev;
    logic [2:0]    run, run_nxt;

    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) rst_q <= '0;
        else          rst_q <= {rst_q[0], 1'b1};

    assign rst_n = rst_q[1];

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) sd_q <= 2'b11;
        else        sd_q <= {sd_q[0], joy_data};

    assign sd      = sd_q[1];
    assign tick    = (cnt == CLAST);
    assign run_nxt = (shadow != prev) ? 3'd1 : (run < DB) ? run + 3'd1 : run;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= LOAD;
            cnt      <= '0;
            idx      <= '0;
            gcnt     <= '0;
            shadow   <= '0;
            prev     <= '0;
            run      <= '0;
            joy_clk  <= 1'b0;
            joy_load <= 1'b0;
            joystick <= '0;
            frame    <= 1'b0;
            present  <= 1'b0;
        end else begin
            // LATCH holds the tick phase so the gap starts a full tick after the compare
            cnt   <= (tick || state == LATCH) ? '0 : cnt + 1'b1;
            frame <= 1'b0;
            case (state)
                LOAD: begin
                    joy_load <= !tick;
                    if (tick) state <= SETTLE;
                end
                SETTLE: if (tick) state <= LOW;
                LOW: if (tick) begin
                    shadow[idx] <= ~sd;
                    joy_clk     <= (idx != ILAST);
                    state       <= (idx == ILAST) ? LATCH : HIGH;
                end
                HIGH: if (tick) begin
                    idx     <= idx + 1'b1;
                    joy_clk <= 1'b0;
                    state   <= LOW;
                end
                LATCH: begin
                    prev    <= shadow;
                    run     <= run_nxt;
                    present <= |shadow;
                    frame   <= 1'b1;
                    idx     <= '0;
                    gcnt    <= '0;
                    state   <= GAP;
                    if (run_nxt >= DB) joystick <= shadow;
                end
                GAP: if (tick) begin
                    gcnt <= gcnt + 1'b1;
                    if (gcnt == GLAST) begin
                        joy_load <= 1'b1;
                        state    <= LOAD;
                    end
                end
                default: state <= LOAD;
            endcase
        end
    end
endmodule

// File: tb/tb_joy_serial_reader.sv
// tb_joy_serial_reader: two reader configurations driven by behavioural shift-register adapters,
// checked against a frame-history debounce model.
module tb_joy_serial_reader;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_a_n, rst_b_n, jdata_a, jdata_b, jclk_a, jclk_b, jload_a, jload_b;
    logic        frame_a, frame_b, present_a, present_b;
    logic [23:0] joy_a;
    logic [63:0] joy_b;
    logic [63:0] pat_a, pat_b, exp_a, exp_b;
    logic        unplug_a, glitch_b, gval;
    int          sa = 0, sb = 0;
    int          total = 0, passed = 0, failed = 0;
    logic [63:0] ha[$], hb[$];

    joy_serial_reader #(.PLAYERS(2), .BITS(12), .SHIFT_DIV(4), .GAP_TICKS(8), .DEBOUNCE(1)) dut_a (
        .clk(clk), .reset_n(rst_a_n), .joy_data(jdata_a), .joy_clk(jclk_a), .joy_load(jload_a),
        .joystick(joy_a), .frame(frame_a), .present(present_a));

    joy_serial_reader #(.PLAYERS(4), .BITS(16), .SHIFT_DIV(4), .GAP_TICKS(8), .DEBOUNCE(3)) dut_b (
        .clk(clk), .reset_n(rst_b_n), .joy_data(jdata_b), .joy_clk(jclk_b), .joy_load(jload_b),
        .joystick(joy_b), .frame(frame_b), .present(present_b));

    // Adapters: load resets the shift position, each rising shift clock presents the next bit
    always @(posedge jload_a) sa = 0;
    always @(posedge jclk_a) sa = sa + 1;
    always @(posedge jload_b) sb = 0;
    always @(posedge jclk_b) sb = sb + 1;
    always @(negedge clk) gval = 1'($urandom);

    assign jdata_a = unplug_a | ~pat_a[sa];
    assign jdata_b = (glitch_b && jclk_b) ? gval : ~pat_b[sb];

    function automatic logic [63:0] debounced(input logic [63:0] h[$], input int db, input logic [63:0] held);
        int s = 0;
        logic [63:0] last = h[h.size()-1];
        for (int i = h.size() - 1; i >= 0; i--)
            if (h[i] == last) s++;
            else break;
        return (s >= db) ? last : held;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_frame(input bit b, input int limit, output int cyc);
        cyc = 0;
        do begin
            @(posedge clk); #1; cyc++;
        end while (!(b ? frame_b : frame_a) && cyc < limit);
        check(b ? "strobe_b" : "strobe_a", 64'(b ? frame_b : frame_a), 64'd1);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [63:0] pa, pb, pc;
        int cyc, hi, rises, per, n;
        logic pcl, pl;
        rst_a_n = 0; rst_b_n = 0; pat_a = 0; pat_b = 0; unplug_a = 0; glitch_b = 0;
        exp_a = 0; exp_b = 0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_clk", jclk_a, 0);
        check("rst_load", jload_a, 0);
        check("rst_joy", joy_a, 0);
        check("rst_present", present_a, 0);
        check("rst_frame", frame_a, 0);

        pat_a = 64'h001008;
        @(negedge clk) rst_a_n = 1;
        wait_frame(0, 400, cyc);
        ha.push_back(pat_a); exp_a = debounced(ha, 1, exp_a);
        check("t1_joy", joy_a, 64'h001008);
        check("t1_present", present_a, 1);

        for (int i = 0; i < 6; i++) begin
            pat_a = (i == 3) ? 64'd0 : 64'($urandom) & 64'hFFFFFF;
            wait_frame(0, 400, cyc);
            ha.push_back(pat_a); exp_a = debounced(ha, 1, exp_a);
            check("rand_joy", joy_a, exp_a);
            check("rand_present", present_a, 64'(pat_a != 0));
        end

        n = 0;
        while (!jload_a && n < 400) begin @(posedge clk); #1; n++; end
        check("t2_load_rise", jload_a, 1);
        hi = 1; rises = 0; per = 0; pl = 1; pcl = jclk_a;
        for (int i = 0; i < 600; i++) begin
            @(posedge clk); #1; per++;
            if (jload_a && !pl) break;
            hi += int'(jload_a);
            rises += int'(jclk_a && !pcl);
            pl = jload_a; pcl = jclk_a;
        end
        ha.push_back(pat_a); exp_a = debounced(ha, 1, exp_a);
        check("t2_load_width", hi, 4);
        check("t2_clk_rises", rises, 23);
        check("t2_period", per, 229);

        unplug_a = 1;
        wait_frame(0, 400, cyc);
        ha.push_back(0); exp_a = debounced(ha, 1, exp_a);
        check("t4_joy", joy_a, exp_a);
        check("t4_present", present_a, 0);
        wait_frame(0, 400, cyc);
        ha.push_back(0); exp_a = debounced(ha, 1, exp_a);
        check("t4_period", cyc, 229);
        check("t4_joy2", joy_a, exp_a);
        check("t4_present2", present_a, 0);
        unplug_a = 0;

        pat_a = (64'($urandom) & 64'hFFFFFF) | 64'h1;
        wait_frame(0, 400, cyc);
        ha.push_back(pat_a); exp_a = debounced(ha, 1, exp_a);
        check("t5_before", joy_a, exp_a);
        rises = 0; pcl = jclk_a;
        for (int i = 0; i < 400 && rises < 11; i++) begin
            @(posedge clk); #1;
            rises += int'(jclk_a && !pcl);
            pcl = jclk_a;
        end
        check("t5_mid_rises", rises, 11);
        rst_a_n = 0;
        #1;
        check("t5_clk", jclk_a, 0);
        check("t5_load", jload_a, 0);
        check("t5_joy", joy_a, 0);
        check("t5_present", present_a, 0);
        pa = (64'($urandom) & 64'hFFFFFF) | 64'h800000;
        pat_a = pa;
        ha.delete(); exp_a = 0;
        repeat (3) @(posedge clk);
        @(negedge clk) rst_a_n = 1;
        n = 0;
        while (!jload_a && !jclk_a && n < 100) begin @(posedge clk); #1; n++; end
        check("t5_first_load", jload_a, 1);
        check("t5_first_clk", jclk_a, 0);
        wait_frame(0, 400, cyc);
        ha.push_back(pa); exp_a = debounced(ha, 1, exp_a);
        check("t5_full_frame", joy_a, exp_a);
        check("t5_present_after", present_a, 1);

        pa = {$urandom, $urandom} | 64'h1;
        pb = pa ^ {$urandom, $urandom | 32'h1};
        pat_b = pa;
        @(negedge clk) rst_b_n = 1;
        for (int i = 0; i < 5; i++) begin
            wait_frame(1, 1200, cyc);
            hb.push_back(pat_b); exp_b = debounced(hb, 3, exp_b);
            check("t3_joy", joy_b, exp_b);
            if (i == 1) pat_b = pb;
        end
        check("t3_final", joy_b, pb);

        pc = {$urandom, $urandom};
        glitch_b = 1;
        pat_b = pc;
        for (int i = 0; i < 3; i++) begin
            wait_frame(1, 1200, cyc);
            hb.push_back(pc); exp_b = debounced(hb, 3, exp_b);
            check("t6_joy", joy_b, exp_b);
            check("t6_present", present_b, 64'(pc != 0));
        end
        check("t6_player3", joy_b[63:48], pc[63:48]);
        glitch_b = 0;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
